ir_key_fifo: RTL and testbench
==============================

Name: ir_key_fifo

Overview:
Consumer stage placed directly downstream of the IR remote decoder. Captures each decoded key code (8-bit code plus multi-cycle ready pulse) into a small first-word-fall-through FIFO. Presents keys to the application logic with a valid/ack handshake. Also provides a decimal-digit decode of the head key and a sticky overflow flag.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of two, 2..256.
ADDR_W, 3, log2(DEPTH); pointer width.
HOLDOFF, 16'd50000, repeat-suppression window in clk cycles (used only with the optional feature).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-low.
tecla  input  8  key code from decoder; 8'hFF = no key.
ready  input  1  decoder strobe; high for several consecutive cycles per key.
key_ack  input  1  consumer pops the head entry when key_valid is also high.
clear_ovf  input  1  clears overflow.
key_out  output  8  head-of-FIFO key code (FWFT); 8'hFF when empty.
key_valid  output  1  FIFO not empty.
is_digit  output  1  head code is in 8'h00..8'h09 and key_valid=1.
digit  output  4  head code[3:0] when is_digit=1, else 4'hF.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a key was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - pointers = 0, count = 0, key_valid = 0, key_out = 8'hFF;
  - is_digit = 0, digit = 4'hF, overflow = 0;
  - ready edge register = 0, last_key = 8'hFF, holdoff counter = 0.
  - Reset mid-operation discards all stored keys. FIFO memory contents need not be cleared.
- Capture:
  - ready_q is ready registered. A push request occurs on the cycle where ready=1 and ready_q=0 (rising edge).
  - Only one push per ready pulse, regardless of pulse length.
  - The request is ignored if tecla == 8'hFF.
- Push:
  - Writes tecla at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - The entry is visible on key_out the cycle after the push edge (1-cycle latency).
- Pop:
  - Occurs when key_valid && key_ack. rd_ptr increments and wraps; key_out shows the next entry the following cycle.
  - key_ack while empty has no effect.
- Simultaneous push and pop:
  - Both execute and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and no overflow occurs.
- Full, push without pop: the key is dropped, overflow <= 1, count stays DEPTH.
- Empty: key_valid = 0, key_out = 8'hFF.
- Overflow flag:
  - Cleared by clear_ovf=1.
  - If clear_ovf and a new drop occur in the same cycle, the set wins.
- Derived outputs: is_digit and digit are combinational from key_out and key_valid.
- count width is ADDR_W+1, so count == DEPTH is representable.

Optional Feature:
IR_KEY_REPEAT_FILTER_EN
- Defined:
  - A 16-bit holdoff counter reloads to HOLDOFF on every ready rising edge (accepted or not) and decrements to 0.
  - A push request whose tecla equals last_key while the counter is non-zero is suppressed: no push, no overflow.
  - last_key updates on every accepted push.
- Undefined: no counter and no last_key register; every qualifying rising edge pushes.

Test Plan:
1. Reset, then a ready pulse 4 cycles long with tecla=8'h05 → exactly one push; next cycle key_valid=1, key_out=8'h05, is_digit=1, digit=4'h5, count=1.
2. Push 8'h12, then assert key_ack for one cycle → key_valid=0, key_out=8'hFF, count=0. A further key_ack while empty leaves count=0.
3. Push 9 distinct codes 8'h00..8'h08 with DEPTH=8 and no ack → count=8, overflow=1. Pop all: order 00..07. Pulse clear_ovf → overflow=0.
4. With FIFO full, a ready rising edge coincides with key_ack → count stays 8, overflow stays 0, newest code is at the tail.
5. Ready pulse with tecla=8'hFF → no push, count unchanged. Also assert rst=0 with 3 entries stored → count=0, key_valid=0 next cycle.
6. With IR_KEY_REPEAT_FILTER_EN and HOLDOFF=100:
   - Two 8'h07 pulses 40 cycles apart → one entry.
   - A third 8'h07 pulse 150 cycles after the second → second entry.
   - A 8'h08 pulse 10 cycles later → accepted.
   - Without the macro, all four pulses push.

Source files
------------

// File: rtl/ir_key_fifo_if.sv
// Key FIFO bus: decoder-side capture inputs plus the application-side
// valid/ack head-of-queue view. The master drives the decoder and ack signals.
interface ir_key_fifo_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]      tecla;
    logic            ready;
    logic            key_ack;
    logic            clear_ovf;
    logic [7:0]      key_out;
    logic            key_valid;
    logic            is_digit;
    logic [3:0]      digit;
    logic [ADDR_W:0] count;
    logic            overflow;

    // key_valid/key_ack: the head entry is consumed on any cycle where both are high;
    // key_out holds steady until then, and ack without valid is ignored.
    modport master (
        output tecla, ready, key_ack, clear_ovf,
        input  key_out, key_valid, is_digit, digit, count, overflow
    );

    modport slave (
        input  tecla, ready, key_ack, clear_ovf,
        output key_out, key_valid, is_digit, digit, count, overflow
    );
endinterface

// File: rtl/ir_key_fifo.sv
// First-word-fall-through key FIFO behind the IR decoder, one push per ready pulse.
// Optional repeat suppression is enabled with `define IR_KEY_REPEAT_FILTER_EN.
module ir_key_fifo #(
    parameter int          DEPTH   = 8,
    parameter int          ADDR_W  = 3,
    parameter logic [15:0] HOLDOFF = 16'd50000
) (
    input logic           clk,
    input logic           rst,
    ir_key_fifo_if.slave  key_if
);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      NO_KEY   = 8'hFF;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ready_q;
    logic              overflow_q, overflow_d;

    logic rise, repeat_hit, push_req, full, pop, push, drop;

    assign rise     = key_if.ready && !ready_q;
    assign push_req = rise && (key_if.tecla != NO_KEY) && !repeat_hit;
    assign full     = (count_q == CNT_FULL);
    assign pop      = (count_q != '0) && key_if.key_ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

`ifdef IR_KEY_REPEAT_FILTER_EN
    logic [15:0] holdoff_q, holdoff_d;
    logic [7:0]  last_key_q, last_key_d;

    assign repeat_hit = (key_if.tecla == last_key_q) && (holdoff_q != 16'd0);

    always_comb begin
        holdoff_d  = holdoff_q;
        last_key_d = last_key_q;
        if (rise)
            holdoff_d = HOLDOFF;
        else if (holdoff_q != 16'd0)
            holdoff_d = holdoff_q - 16'd1;
        if (push)
            last_key_d = key_if.tecla;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            holdoff_q  <= 16'd0;
            last_key_q <= NO_KEY;
        end else begin
            holdoff_q  <= holdoff_d;
            last_key_q <= last_key_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push)
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (push && !pop)
            count_d = count_q + (ADDR_W + 1)'(1);
        else if (pop && !push)
            count_d = count_q - (ADDR_W + 1)'(1);
        if (drop)
            overflow_d = 1'b1;
        else if (key_if.clear_ovf)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= key_if.ready;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= key_if.tecla;
    end

    assign key_if.key_valid = (count_q != '0);
    assign key_if.key_out   = key_if.key_valid ? mem_q[rd_ptr_q] : NO_KEY;
    assign key_if.is_digit  = key_if.key_valid && (key_if.key_out <= 8'h09);
    assign key_if.digit     = key_if.is_digit ? key_if.key_out[3:0] : 4'hF;
    assign key_if.count     = count_q;
    assign key_if.overflow  = overflow_q;
endmodule

// File: tb/tb_ir_key_fifo.sv
// Bench for ir_key_fifo: directed scenarios plus randomized traffic against a
// queue-based model of the key FIFO, its overflow flag and repeat hold-off.
module tb_ir_key_fifo;
  localparam int          DEPTH   = 8;
  localparam int          ADDR_W  = 3;
  localparam logic [15:0] HOLDOFF = 16'd100;
`ifdef IR_KEY_REPEAT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ir_key_fifo_if #(.ADDR_W(ADDR_W)) key_if ();

  ir_key_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLDOFF(HOLDOFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .key_if (key_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] exp_q[$];
  bit         m_ovf;
  bit         m_prev_ready;
  bit         m_rise_seen;
  logic [7:0] m_last_key;
  longint     m_cyc;
  longint     m_last_rise;

  function automatic void model_step();
    bit pop, rise, req, full, suppress;
    if (!rst) begin
      exp_q.delete();
      m_ovf = 0; m_prev_ready = 0; m_rise_seen = 0; m_last_key = 8'hFF;
      m_cyc++;
      return;
    end
    pop  = (exp_q.size() != 0) && key_if.key_ack;
    rise = key_if.ready && !m_prev_ready;
    suppress = FILTER && m_rise_seen && (key_if.tecla == m_last_key) &&
               ((m_cyc - m_last_rise) <= longint'(HOLDOFF));
    req  = rise && (key_if.tecla != 8'hFF) && !suppress;
    full = (exp_q.size() == DEPTH);
    if (rise) begin
      m_last_rise = m_cyc;
      m_rise_seen = 1;
    end
    if (pop) void'(exp_q.pop_front());
    if (req && (!full || pop)) begin
      exp_q.push_back(key_if.tecla);
      m_last_key = key_if.tecla;
    end
    if (req && full && !pop) m_ovf = 1;
    else if (key_if.clear_ovf) m_ovf = 0;
    m_prev_ready = key_if.ready;
    m_cyc++;
  endfunction

  // {key_valid, key_out, count, overflow, is_digit, digit}
  function automatic logic [18:0] exp_outs();
    logic       v;
    logic [7:0] k;
    logic       d;
    v = (exp_q.size() != 0);
    k = v ? exp_q[0] : 8'hFF;
    d = v && (k <= 8'h09);
    return {v, k, 4'(exp_q.size()), m_ovf, d, d ? k[3:0] : 4'hF};
  endfunction

  wire [18:0] obs_outs = {key_if.key_valid, key_if.key_out, key_if.count,
                          key_if.overflow, key_if.is_digit, key_if.digit};

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [7:0] code, input int len);
    key_if.tecla = code;
    key_if.ready = 1'b1;
    repeat (len) tick();
    key_if.ready = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    key_if.tecla = 8'hFF; key_if.ready = 0; key_if.key_ack = 0; key_if.clear_ovf = 0;
    do_reset();
    checks++;
    if (obs_outs !== {1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs_outs, {1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 4'hF});
    end
  endtask

  task automatic test_single_push();
    key_if.tecla = 8'h05;
    key_if.ready = 1'b1;
    tick();
    checks++;
    if (obs_outs !== {1'b1, 8'h05, 4'd1, 1'b0, 1'b1, 4'h5}) begin
      errors++;
      $display("FAIL push_latency: got %h want %h", obs_outs, {1'b1, 8'h05, 4'd1, 1'b0, 1'b1, 4'h5});
    end
    idle(3);
    key_if.ready = 1'b0;
    tick();
    checks++;
    if (key_if.count !== 4'd1) begin
      errors++;
      $display("FAIL one_push_per_pulse: count %0d want 1", key_if.count);
    end
  endtask

  task automatic test_pop();
    do_reset();
    pulse(8'h12, 2);
    checks++;
    if (obs_outs !== exp_outs() || key_if.key_out !== 8'h12) begin
      errors++;
      $display("FAIL push_12: got %h want %h", obs_outs, exp_outs());
    end
    key_if.key_ack = 1'b1;
    tick();
    checks++;
    if (obs_outs !== {1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL pop_to_empty: got %h want %h", obs_outs, {1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 4'hF});
    end
    tick();
    key_if.key_ack = 1'b0;
    checks++;
    if (key_if.count !== 4'd0 || key_if.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_while_empty: count %0d valid %b want 0 0", key_if.count, key_if.key_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= 8; i++) pulse(8'(i), 2);
    checks++;
    if (key_if.count !== 4'd8 || key_if.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fill: count %0d ovf %b want 8 1", key_if.count, key_if.overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (key_if.key_out !== 8'(i) || key_if.digit !== 4'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: key %h digit %h want %h", i, key_if.key_out, key_if.digit, 8'(i));
      end
      key_if.key_ack = 1'b1;
      tick();
      key_if.key_ack = 1'b0;
    end
    key_if.clear_ovf = 1'b1;
    tick();
    key_if.clear_ovf = 1'b0;
    checks++;
    if (obs_outs !== {1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL clear_ovf: got %h want %h", obs_outs, {1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 4'hF});
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) pulse(8'h20 + 8'(i), 2);
    key_if.tecla = 8'h30;
    key_if.ready = 1'b1;
    key_if.key_ack = 1'b1;
    tick();
    key_if.key_ack = 1'b0;
    tick();
    key_if.ready = 1'b0;
    tick();
    checks++;
    if (key_if.count !== 4'd8 || key_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: count %0d ovf %b want 8 0", key_if.count, key_if.overflow);
    end
    for (int i = 0; i < 8; i++) begin
      want = (i == 7) ? 8'h30 : 8'h21 + 8'(i);
      checks++;
      if (key_if.key_out !== want) begin
        errors++;
        $display("FAIL tail_order[%0d]: key %h want %h", i, key_if.key_out, want);
      end
      key_if.key_ack = 1'b1;
      tick();
      key_if.key_ack = 1'b0;
    end
  endtask

  task automatic test_no_key_and_reset();
    do_reset();
    pulse(8'h41, 2);
    pulse(8'hFF, 3);
    checks++;
    if (key_if.count !== 4'd1 || key_if.key_out !== 8'h41) begin
      errors++;
      $display("FAIL no_key_ignored: count %0d key %h want 1 41", key_if.count, key_if.key_out);
    end
    pulse(8'h03, 2);
    pulse(8'h0A, 2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (key_if.count !== 4'd0 || key_if.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: count %0d valid %b want 0 0", key_if.count, key_if.key_valid);
    end
  endtask

  task automatic test_repeat_filter();
    logic [3:0] want;
    do_reset();
    pulse(8'h07, 3);
    idle(37);
    pulse(8'h07, 3);
    idle(147);
    pulse(8'h07, 3);
    idle(7);
    pulse(8'h08, 3);
    want = FILTER ? 4'd3 : 4'd4;
    checks++;
    if (key_if.count !== want || obs_outs !== exp_outs()) begin
      errors++;
      $display("FAIL repeat_filter: count %0d want %0d outs %h model %h", key_if.count, want, obs_outs, exp_outs());
    end
  endtask

  task automatic test_random();
    logic [7:0] codes [12];
    for (int i = 0; i < 10; i++) codes[i] = 8'(i);
    codes[10] = 8'h41;
    codes[11] = 8'hFF;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) key_if.ready = ~key_if.ready;
      if (!key_if.ready) codes[0] = codes[0];
      key_if.tecla     = codes[$urandom_range(0, 11)];
      key_if.key_ack   = ($urandom_range(0, 9) < 3);
      key_if.clear_ovf = ($urandom_range(0, 19) == 0);
      rst              = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (obs_outs !== exp_outs()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", c, obs_outs, exp_outs());
      end
    end
    rst = 1'b1;
    key_if.ready = 1'b0; key_if.key_ack = 1'b0; key_if.clear_ovf = 1'b0;
  endtask

  initial begin
    m_cyc = 0; m_last_rise = 0; m_last_key = 8'hFF;
    test_reset();
    test_single_push();
    test_pop();
    test_overflow();
    test_full_push_pop();
    test_no_key_and_reset();
    test_repeat_filter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
